// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
//   Converts the debounced button level into single-cycle UI events for the
//   control FSMs: press, release, short press, long press and an optional
//   auto-repeat pulse while the button stays held past the long threshold.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   -> repeat_pulse_o fires every REPEAT_CYCLES while in LONG
//     undefined -> repeat_pulse_o tied 0, hold counter frozen in LONG
//
// Parameters
//   LONG_PRESS_CYCLES  hold cycles in PRESSED before long_pulse (>= 2)
//   REPEAT_CYCLES      repeat_pulse period while in LONG (>= 2)
//   CNT_W              hold counter width, 2**CNT_W > both cycle counts
//
// Ports
//   clk_i            system clock, all logic on posedge
//   rst_i            synchronous active-high reset
//   btn_level_i      debounced level, 1 = pressed
//   held_o           1 while in PRESSED or LONG
//   press_pulse_o    1-cycle pulse on an accepted press
//   release_pulse_o  1-cycle pulse on release from PRESSED or LONG
//   short_pulse_o    1-cycle pulse on release before the long threshold
//   long_pulse_o     1-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//   repeat_pulse_o   1-cycle periodic pulse while in LONG (macro builds only)
//
// All outputs are registered; each pulse appears in the cycle after the
// btn_level_i sample that decided it.
// -----------------------------------------------------------------------------
module btn_press_classifier #(
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000,
  parameter int unsigned CNT_W             = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_level_i,
  output logic held_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic short_pulse_o,
  output logic long_pulse_o,
  output logic repeat_pulse_o
);

  // Elaboration-time sanity check of the configuration.
  if ((LONG_PRESS_CYCLES < 2) || (REPEAT_CYCLES < 2) || (CNT_W < 2) || (CNT_W > 62) ||
      ((64'd1 << CNT_W) <= 64'(LONG_PRESS_CYCLES)) ||
      ((64'd1 << CNT_W) <= 64'(REPEAT_CYCLES))) begin : g_bad_cfg
    $error("btn_press_classifier: illegal LONG_PRESS_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,  // out of reset; waits for the button to be seen released
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      // A button already down when reset releases must not generate an event:
      // only a seen release arms the classifier.
      ST_ARM: begin
        if (!btn_level_i) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (btn_level_i) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!btn_level_i) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          // The press sample plus LONG_PRESS_CYCLES more high samples lands
          // here, so long_pulse trails press_pulse by exactly the threshold.
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LONG: begin
        if (!btn_level_i) begin
          // Long press already reported; the release never counts as short,
          // and a pending repeat in this cycle is suppressed.
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_q == REP_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          // No repeat: the counter is frozen, so it can never wrap however
          // long the button is held.
          cnt_d = cnt_q;
`endif
        end
      end

      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ARM;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign held_o          = held_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign short_pulse_o   = short_q;
  assign long_pulse_o    = long_q;
  assign repeat_pulse_o  = repeat_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier (LONG=8, REPEAT=4).
// Outputs are compared as one 6-bit vector {held,press,release,short,long,repeat}
// one time unit after every rising edge. Expected timing is relative to k, the
// edge that samples the first high level; the vector checked after edge k+i is
// the cycle "k+i+1".
module tb_btn_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic held, press, rel, shrt, lng, rep;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  btn_press_classifier #(
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R),
    .CNT_W            (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .btn_level_i    (btn),
    .held_o         (held),
    .press_pulse_o  (press),
    .release_pulse_o(rel),
    .short_pulse_o  (shrt),
    .long_pulse_o   (lng),
    .repeat_pulse_o (rep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b (held,press,rel,short,long,rep) t=%0t", tag, got, exp, $time);
    end
  endtask

  // drive one sample, let it be clocked in, settle
  task automatic tick(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {held, press, rel, shrt, lng, rep};
  endfunction

  // idle low samples; nothing may fire
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0);
      chk(tag, obs(), 6'b0);
    end
  endtask

  // Button high for hi samples starting at k, then low. Expectations:
  //   held k+1..k+hi, press @k+1, release @k+hi+1,
  //   short @k+hi+1 when hi <= L, else long @k+L+1,
  //   repeat @k+L+1+n*R while still high (macro build only).
  task automatic press_run(input string tag, input int hi);
    bit is_long;
    logic [5:0] e;
    is_long = (hi >= L + 1);
    for (int i = 0; i < hi + 4; i++) begin
      int c;
      tick(i < hi, 1'b0);
      c = i + 1;
      e[5] = (c >= 1) && (c <= hi);
      e[4] = (c == 1);
      e[3] = (c == hi + 1);
      e[2] = !is_long && (c == hi + 1);
      e[1] = is_long && (c == L + 1);
      e[0] = REP_ON && is_long && (c > L + 1) && (c <= hi) && (((c - L - 1) % R) == 0);
      chk($sformatf("%s c=k+%0d", tag, c), obs(), e);
    end
  endtask

  initial begin
    // 1. reset with button released
    tick(1'b0, 1'b1);
    chk("rst0", obs(), 6'b0);
    tick(1'b0, 1'b1);
    chk("rst1", obs(), 6'b0);
    quiet("idle20", 20);

    // 2. short press, 5 samples
    press_run("short5", 5);
    quiet("gap", 3);

    // single-sample press
    press_run("short1", 1);
    quiet("gap", 3);

    // 3. threshold boundary: 8 samples short, 9 samples long
    press_run("short8", L);
    quiet("gap", 3);
    press_run("long9", L + 1);
    quiet("gap", 3);

    // 4. long hold with auto-repeat (repeat stays 0 without the macro)
    press_run("long20", 20);
    quiet("gap", 3);

    // 5. reset during a press, button held to k+30, re-press at k+40
    for (int i = 0; i <= 45; i++) begin
      int c;
      logic [5:0] e;
      tick((i <= 30) || (i >= 40 && i <= 43), (i == 3));
      c = i + 1;
      e = 6'b0;
      e[5] = (c >= 1 && c <= 3) || (c >= 41 && c <= 44);
      e[4] = (c == 1) || (c == 41);
      e[3] = (c == 45);
      e[2] = (c == 45);
      chk($sformatf("midrst c=k+%0d", c), obs(), e);
    end
    quiet("gap", 3);

    // 6. button held through reset: no event until a fresh press
    tick(1'b1, 1'b1);
    chk("hold_rst0", obs(), 6'b0);
    tick(1'b1, 1'b1);
    chk("hold_rst1", obs(), 6'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      chk("hold_arm", obs(), 6'b0);
    end
    tick(1'b0, 1'b0);
    chk("arm_rel", obs(), 6'b0);
    tick(1'b1, 1'b0);
    chk("arm_press", obs(), 6'b110000);
    tick(1'b0, 1'b0);
    chk("arm_short", obs(), 6'b001100);
    quiet("tail", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
